// File: rtl/fft_out_stream_sink.sv
`default_nettype none
// ============================================================================
// Module  : fft_out_stream_sink
// Brief   : FFT result stream sink: denormalises block-floating-point beats,
//           checks frame integrity and buffers results in a FWFT FIFO.
// Revision: 1.0
// ============================================================================

module fft_out_stream_sink #(
    parameter int LOGS_FFT_LEN  = 13,
    parameter int OUTPUT_WIDTH  = 10,
    parameter int DATAOUT_WIDTH = 16,
    parameter int USER_WIDTH    = 24,
    parameter int OUT_WIDTH     = 24,
    parameter int FIFO_AW       = 4
) (
    input  logic                       i_aclk,
    input  logic                       i_areset,
    input  logic                       i_axi4s_data_tvalid,
    input  logic [2*DATAOUT_WIDTH-1:0] i_axi4s_data_tdata,
    input  logic                       i_axi4s_data_tlast,
    input  logic [USER_WIDTH-1:0]      i_axi4s_data_tuser,
    output logic                       o_m_tvalid,
    input  logic                       i_m_tready,
    output logic [2*OUT_WIDTH-1:0]     o_m_tdata,
    output logic                       o_m_tlast,
    output logic [LOGS_FFT_LEN:0]      o_m_tuser,
    input  logic                       i_err_clr,
    output logic [3:0]                 o_err,
    output logic                       o_sat,
    output logic [15:0]                o_frame_cnt
);
    localparam int                    c_MAX_SHIFT = OUT_WIDTH - OUTPUT_WIDTH;
    localparam int                    c_DEPTH     = 1 << FIFO_AW;
    localparam int                    c_ENTRY_W   = 2*OUT_WIDTH + LOGS_FFT_LEN + 2;
    localparam logic [FIFO_AW:0]      c_FULL_CNT  = (FIFO_AW+1)'(c_DEPTH);
    localparam logic [LOGS_FFT_LEN-1:0] c_LAST_IDX = '1;

    function automatic logic [OUT_WIDTH-1:0] f_denorm(
        input logic [OUTPUT_WIDTH-1:0] comp,
        input logic [7:0]              sh
    );
        logic [OUT_WIDTH-1:0] ext;
        logic [OUT_WIDTH-1:0] res;
        ext = OUT_WIDTH'($signed(comp));
        if (int'(sh) > c_MAX_SHIFT) begin
            if (comp == '0)                 res = '0;
            else if (comp[OUTPUT_WIDTH-1])  res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            else                            res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
            res = ext << sh;
        end
        return res;
    endfunction

    // S1: raw unpacked beat
    logic                    r_s1_valid, r_s1_last;
    logic [OUTPUT_WIDTH-1:0] r_s1_re, r_s1_im;
    logic [LOGS_FFT_LEN-1:0] r_s1_idx;
    logic [7:0]              r_s1_exp;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
            r_s1_idx   <= '0;
            r_s1_exp   <= '0;
        end else begin
            r_s1_valid <= i_axi4s_data_tvalid;
            r_s1_last  <= i_axi4s_data_tlast;
            r_s1_re    <= i_axi4s_data_tdata[OUTPUT_WIDTH-1:0];
            r_s1_im    <= i_axi4s_data_tdata[DATAOUT_WIDTH +: OUTPUT_WIDTH];
            r_s1_idx   <= i_axi4s_data_tuser[LOGS_FFT_LEN-1:0];
            r_s1_exp   <= i_axi4s_data_tuser[USER_WIDTH-1 -: 8];
        end
    end

    // S2: denormalised beat, checked and written to the FIFO on the next edge
    logic                    r_s2_valid, r_s2_last, r_s2_sat;
    logic [OUT_WIDTH-1:0]    r_s2_re, r_s2_im;
    logic [LOGS_FFT_LEN-1:0] r_s2_idx;
    logic [7:0]              r_s2_exp;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_s2_re    <= '0;
            r_s2_im    <= '0;
            r_s2_idx   <= '0;
            r_s2_exp   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_sat   <= int'(r_s1_exp) > c_MAX_SHIFT;
            r_s2_re    <= f_denorm(r_s1_re, r_s1_exp);
            r_s2_im    <= f_denorm(r_s1_im, r_s1_exp);
            r_s2_idx   <= r_s1_idx;
            r_s2_exp   <= r_s1_exp;
        end
    end

    logic [LOGS_FFT_LEN-1:0] r_exp_idx;
    logic [7:0]              r_blk_exp;
    logic                    r_exp_vld, r_frame_bad, r_sat;
    logic [3:0]              r_err;
    logic [15:0]             r_frame_cnt;
    logic [FIFO_AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]        r_count;
    logic [c_ENTRY_W-1:0]    r_mem [c_DEPTH];

    logic w_idx_err, w_last_err, w_exp_err, w_full, w_rd, w_wr, w_drop, w_beat_bad;
    logic [3:0]           w_err_evt;
    logic [c_ENTRY_W-1:0] w_rd_entry;

    assign w_idx_err  = r_s2_idx != r_exp_idx;
    assign w_last_err = r_s2_last != (r_exp_idx == c_LAST_IDX);
    assign w_exp_err  = r_exp_vld && (r_s2_idx != '0) && (r_s2_exp != r_blk_exp);
    assign w_full     = r_count == c_FULL_CNT;
    assign w_rd       = o_m_tvalid && i_m_tready;
    // A read in the same cycle frees a slot, so a full FIFO still accepts
    assign w_wr       = r_s2_valid && (!w_full || w_rd);
    assign w_drop     = r_s2_valid && !w_wr;
    assign w_beat_bad = r_frame_bad | w_idx_err | w_last_err | w_exp_err | w_drop;
    assign w_err_evt  = r_s2_valid ? {w_drop, w_exp_err, w_last_err, w_idx_err} : 4'b0000;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_exp_idx   <= '0;
            r_blk_exp   <= '0;
            r_exp_vld   <= 1'b0;
            r_frame_bad <= 1'b0;
            r_err       <= '0;
            r_sat       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_err <= (i_err_clr ? 4'b0000 : r_err) | w_err_evt;
            r_sat <= (i_err_clr ? 1'b0 : r_sat) | (r_s2_valid & r_s2_sat);
            if (r_s2_valid) begin
                // Normal advance and resync after a skip both land on index+1
                r_exp_idx   <= r_s2_idx + 1'b1;
                r_frame_bad <= r_s2_last ? 1'b0 : w_beat_bad;
                if (r_s2_idx == '0) begin
                    r_blk_exp <= r_s2_exp;
                    r_exp_vld <= 1'b1;
                end
                if (r_s2_last) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_s2_im, r_s2_re, r_s2_last, w_beat_bad, r_s2_idx};
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Outputs are gated so an empty FIFO presents zeros, not stale memory
    assign w_rd_entry  = r_mem[r_rd_ptr];
    assign o_m_tvalid  = r_count != '0;
    assign o_m_tdata   = o_m_tvalid ? w_rd_entry[c_ENTRY_W-1 -: 2*OUT_WIDTH] : '0;
    assign o_m_tlast   = o_m_tvalid ? w_rd_entry[LOGS_FFT_LEN+1] : 1'b0;
    assign o_m_tuser   = o_m_tvalid ? w_rd_entry[LOGS_FFT_LEN:0] : '0;
    assign o_err       = r_err;
    assign o_sat       = r_sat;
    assign o_frame_cnt = r_frame_cnt;

    logic w_unused_bits;
    assign w_unused_bits = ^{i_axi4s_data_tdata[DATAOUT_WIDTH-1:OUTPUT_WIDTH],
                             i_axi4s_data_tdata[2*DATAOUT_WIDTH-1:DATAOUT_WIDTH+OUTPUT_WIDTH],
                             i_axi4s_data_tuser[USER_WIDTH-9:LOGS_FFT_LEN]};

endmodule

`default_nettype wire

// File: tb/tb_fft_out_stream_sink.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_out_stream_sink
// Brief   : Directed self-checking bench for fft_out_stream_sink.
// Revision: 1.0
// ============================================================================

module tb_fft_out_stream_sink;
    localparam int c_FRAME = 8192;

    logic        clk = 1'b0;
    logic        i_areset = 1'b1;
    logic        i_tvalid = 1'b0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic [23:0] i_tuser = '0;
    logic        o_m_tvalid;
    logic        i_m_tready = 1'b0;
    logic [47:0] o_m_tdata;
    logic        o_m_tlast;
    logic [13:0] o_m_tuser;
    logic        i_err_clr = 1'b0;
    logic [3:0]  o_err;
    logic        o_sat;
    logic [15:0] o_frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fft_out_stream_sink dut (
        .i_aclk              (clk),
        .i_areset            (i_areset),
        .i_axi4s_data_tvalid (i_tvalid),
        .i_axi4s_data_tdata  (i_tdata),
        .i_axi4s_data_tlast  (i_tlast),
        .i_axi4s_data_tuser  (i_tuser),
        .o_m_tvalid          (o_m_tvalid),
        .i_m_tready          (i_m_tready),
        .o_m_tdata           (o_m_tdata),
        .o_m_tlast           (o_m_tlast),
        .o_m_tuser           (o_m_tuser),
        .i_err_clr           (i_err_clr),
        .o_err               (o_err),
        .o_sat               (o_sat),
        .o_frame_cnt         (o_frame_cnt)
    );

    typedef struct packed {
        logic [9:0]  re;
        logic [9:0]  im;
        logic [7:0]  ex;
        logic [23:0] want_re;
        logic [23:0] want_im;
        logic        want_sat;
    } vec_t;

    typedef struct {
        logic [23:0] re;
        logic [23:0] im;
        logic        last;
        logic        bad;
        logic [12:0] idx;
    } beat_t;

    beat_t rxq[$];

    // Transfers are captured mid-cycle; they complete on the following edge
    always @(negedge clk) begin
        if (!i_areset && o_m_tvalid && i_m_tready) begin
            rxq.push_back('{o_m_tdata[23:0], o_m_tdata[47:24], o_m_tlast,
                            o_m_tuser[13], o_m_tuser[12:0]});
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_tvalid  = 1'b0;
        i_err_clr = 1'b0;
        i_areset  = 1'b1;
        tick();
        tick();
        i_areset  = 1'b0;
    endtask

    task automatic drive(input logic [9:0] re, input logic [9:0] im, input logic [7:0] ex,
                         input logic [12:0] idx, input logic lst);
        i_tvalid = 1'b1;
        i_tdata  = {{6{im[9]}}, im, {6{re[9]}}, re};
        i_tlast  = lst;
        i_tuser  = {ex, 3'b000, idx};
    endtask

    task automatic send_frame(input logic [7:0] ex, input logic [9:0] re, input logic [9:0] im,
                              input int skip_idx, input int early_last, input int exp_chg,
                              input int stop_at);
        logic lst;
        for (int k = 0; k < c_FRAME; k++) begin
            if (k == skip_idx) continue;
            lst = (k == c_FRAME-1) || (k == early_last);
            drive(re, im, (k == exp_chg) ? ex + 8'd1 : ex, k[12:0], lst);
            tick();
            if (lst || k == stop_at) break;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    vec_t vecs[8];
    int   lat, nbad, eidx, chg;
    logic [47:0] held;
    logic held_v;

    initial begin
        vecs[0] = '{10'h001, 10'h3FF, 8'd3,   24'h000008, 24'hFFFFF8, 1'b0};
        vecs[1] = '{10'h1FF, 10'h200, 8'd15,  24'h7FFFFF, 24'h800000, 1'b1};
        vecs[2] = '{10'h001, 10'h000, 8'd14,  24'h004000, 24'h000000, 1'b0};
        vecs[3] = '{10'h1FF, 10'h200, 8'd14,  24'h7FC000, 24'h800000, 1'b0};
        vecs[4] = '{10'h155, 10'h2AB, 8'd0,   24'h000155, 24'hFFFEAB, 1'b0};
        vecs[5] = '{10'h000, 10'h3FF, 8'd200, 24'h000000, 24'h800000, 1'b1};
        vecs[6] = '{10'h100, 10'h001, 8'd20,  24'h7FFFFF, 24'h7FFFFF, 1'b1};
        vecs[7] = '{10'h3FE, 10'h0FF, 8'd7,   24'hFFFF00, 24'h007F80, 1'b0};

        do_reset();
        chk("rst_tvalid", o_m_tvalid, 0);
        chk("rst_tdata", o_m_tdata, 0);
        chk("rst_tlast_tuser", {o_m_tlast, o_m_tuser}, 0);
        chk("rst_err_sat", {o_err, o_sat}, 0);
        chk("rst_frame_cnt", o_frame_cnt, 0);

        // Arithmetic table: one index-0 beat per vector, held at the output
        for (int v = 0; v < 8; v++) begin
            i_m_tready = 1'b0;
            do_reset();
            drive(vecs[v].re, vecs[v].im, vecs[v].ex, 13'd0, 1'b0);
            tick();
            i_tvalid = 1'b0;
            lat = 1;
            while (!o_m_tvalid && lat < 20) begin
                tick();
                lat++;
            end
            chk($sformatf("vec%0d_latency", v), lat, 3);
            chk($sformatf("vec%0d_tdata", v), o_m_tdata, {vecs[v].want_im, vecs[v].want_re});
            chk($sformatf("vec%0d_sat", v), o_sat, vecs[v].want_sat);
            chk($sformatf("vec%0d_tuser_tlast", v), {o_m_tlast, o_m_tuser}, 0);
            chk($sformatf("vec%0d_err", v), o_err, 0);
        end

        // Nominal frame
        do_reset();
        i_m_tready = 1'b1;
        rxq.delete();
        send_frame(8'd3, 10'h001, 10'h3FF, -1, -1, -1, -1);
        drain(20);
        nbad = 0;
        foreach (rxq[k]) begin
            if (rxq[k].re !== 24'd8 || rxq[k].im !== 24'hFFFFF8 || rxq[k].idx !== k[12:0] ||
                rxq[k].last !== (k == c_FRAME-1) || rxq[k].bad !== 1'b0) nbad++;
        end
        chk("nom_count", rxq.size(), c_FRAME);
        chk("nom_bad_beats", nbad, 0);
        chk("nom_frame_cnt", o_frame_cnt, 1);
        chk("nom_err_sat", {o_err, o_sat}, 0);

        // Index skip 98 -> 100, then a clean frame
        do_reset();
        rxq.delete();
        send_frame(8'd3, 10'h001, 10'h3FF, 99, -1, -1, -1);
        send_frame(8'd3, 10'h001, 10'h3FF, -1, -1, -1, -1);
        drain(20);
        nbad = 0;
        foreach (rxq[k]) begin
            if (k < c_FRAME-1) begin
                eidx = (k < 99) ? k : k + 1;
                if (rxq[k].idx !== eidx[12:0] || rxq[k].bad !== (eidx >= 100) ||
                    rxq[k].last !== (eidx == c_FRAME-1)) nbad++;
            end else begin
                eidx = k - (c_FRAME-1);
                if (rxq[k].idx !== eidx[12:0] || rxq[k].bad !== 1'b0 ||
                    rxq[k].last !== (eidx == c_FRAME-1)) nbad++;
            end
        end
        chk("skip_count", rxq.size(), 2*c_FRAME-1);
        chk("skip_bad_beats", nbad, 0);
        chk("skip_err", o_err, 4'b0001);
        chk("skip_frame_cnt", o_frame_cnt, 2);

        // Exponent change at index 200, then early tlast at index 50
        do_reset();
        rxq.delete();
        send_frame(8'd3, 10'h001, 10'h3FF, -1, -1, 200, -1);
        drain(20);
        nbad = 0;
        foreach (rxq[k]) if (rxq[k].bad) nbad++;
        chk("expchg_count", rxq.size(), c_FRAME);
        chk("expchg_bad_beats", nbad, c_FRAME-200);
        chk("expchg_err", o_err, 4'b0100);
        rxq.delete();
        send_frame(8'd3, 10'h001, 10'h3FF, -1, 50, -1, -1);
        drain(20);
        nbad = 0;
        foreach (rxq[k]) if (rxq[k].bad) nbad++;
        chk("early_count", rxq.size(), 51);
        chk("early_bad_beats", nbad, 1);
        if (rxq.size() > 0) begin
            chk("early_last_beat", {rxq[rxq.size()-1].last, rxq[rxq.size()-1].bad,
                                    rxq[rxq.size()-1].idx}, {2'b11, 13'd50});
        end
        chk("early_err", o_err, 4'b0110);
        chk("early_frame_cnt", o_frame_cnt, 2);

        // Back-pressure: 40 stalled cycles of continuous input
        i_m_tready = 1'b0;
        do_reset();
        rxq.delete();
        held   = '0;
        held_v = 1'b0;
        chg    = 0;
        for (int i = 0; i < 40; i++) begin
            drive(10'(i + 1), 10'h000, 8'd2, 13'(i), 1'b0);
            tick();
            if (o_m_tvalid) begin
                if (!held_v) begin
                    held   = o_m_tdata;
                    held_v = 1'b1;
                end else if (o_m_tdata !== held) begin
                    chg++;
                end
            end
        end
        i_tvalid   = 1'b0;
        i_m_tready = 1'b1;
        chk("bp_held_data", held, {24'd0, 24'd4});
        chk("bp_stable", chg, 0);
        drain(30);
        nbad = 0;
        foreach (rxq[k]) begin
            eidx = (k < 16) ? k : k + 22;
            if (rxq[k].idx !== eidx[12:0] || rxq[k].re !== 24'((eidx + 1) * 4) ||
                rxq[k].im !== 24'd0 || rxq[k].bad !== (k >= 16)) nbad++;
        end
        chk("bp_count", rxq.size(), 18);
        chk("bp_order", nbad, 0);
        chk("bp_err", o_err, 4'b1000);
        chk("bp_empty", o_m_tvalid, 0);

        // Reset mid-frame, then a fresh frame
        do_reset();
        i_m_tready = 1'b1;
        send_frame(8'd3, 10'h005, 10'h000, -1, -1, -1, 4000);
        i_areset = 1'b1;
        rxq.delete();
        tick();
        tick();
        i_areset = 1'b0;
        send_frame(8'd3, 10'h001, 10'h3FF, -1, -1, -1, -1);
        drain(20);
        nbad = 0;
        foreach (rxq[k]) begin
            if (rxq[k].re !== 24'd8 || rxq[k].im !== 24'hFFFFF8 || rxq[k].idx !== k[12:0] ||
                rxq[k].bad !== 1'b0) nbad++;
        end
        chk("rstmid_count", rxq.size(), c_FRAME);
        chk("rstmid_bad_beats", nbad, 0);
        chk("rstmid_err", o_err, 0);
        chk("rstmid_frame_cnt", o_frame_cnt, 1);

        // Error clear coinciding with a new index error: set wins for err[0]
        do_reset();
        drive(10'h001, 10'h000, 8'd3, 13'd0, 1'b0);
        tick();
        drive(10'h001, 10'h000, 8'd3, 13'd2, 1'b1);
        tick();
        drive(10'h001, 10'h000, 8'd3, 13'd7, 1'b0);
        tick();
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        tick();
        chk("clr_pre_err", o_err, 4'b0011);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("clr_set_wins", o_err, 4'b0001);
        tick();
        chk("clr_held", o_err, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
